uart_tx_arbiter: RTL and testbench

Round-robin packet arbiter that shares a single `uart_tx` transmitter among `NUM_REQ` byte-stream requesters. It sits directly in front of the transmitter. It grants one requester at a time, holds the grant for a whole packet (bytes up to and including the one flagged `last`), and paces bytes by issuing one `tx_start` pulse per byte. Between pulses it tracks the transmitter's `tx_busy` rise and fall.

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the packet arbiter.
// The master side is the requesters plus the transmitter; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0][7:0] req_data;   // byte i at bits [8i+7:8i]
   logic [NUM_REQ-1:0]      req_last;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ-1:0]      grant;
   logic                    tx_start;
   logic [7:0]              tx_data;
   logic                    tx_busy;
   logic                    busy;
   logic                    pkt_done;
   logic                    overflow;

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, grant, tx_start, tx_data, busy, pkt_done, overflow
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, grant, tx_start, tx_data, busy, pkt_done, overflow
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a single uart_tx.
// One owner at a time, held for a whole packet; one tx_start per byte,
// paced by the transmitter's busy rise/fall.
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BYTES = 64
) (
   input  logic            clock,
   input  logic            reset,
   uart_tx_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BYTES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_RISE,
      S_WAIT_FALL
   } state_e;

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [PTR_W-1:0]     gidx_q, gidx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 last_q, last_d;
   logic                 tx_start_q, tx_start_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 pkt_done_q, pkt_done_d;
   logic                 overflow_q, overflow_d;

   logic                 found_hi;
   logic [PTR_W-1:0]     idx_hi, idx_lo;
   logic                 pick_found;
   logic [PTR_W-1:0]     pick_idx;
   logic [PTR_W-1:0]     gidx_next;

   // Round-robin pick: lowest set request at or above the pointer, else lowest overall (wrap)
   always_comb begin
      found_hi = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (bus.req_valid[j]) begin
            idx_lo = PTR_W'(j);
            if (PTR_W'(j) >= ptr_q) begin
               found_hi = 1'b1;
               idx_hi   = PTR_W'(j);
            end
         end
      end
      pick_found = |bus.req_valid;
      pick_idx   = found_hi ? idx_hi : idx_lo;
   end

   // Pointer moves past the releasing owner so it becomes lowest priority
   assign gidx_next = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

   // Next-state and registered-pulse computation
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gidx_d      = gidx_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      req_ready_d = '0;
      pkt_done_d  = 1'b0;
      overflow_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d = NUM_REQ'(1) << pick_idx;
               gidx_d  = pick_idx;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // Owner stalls here indefinitely if its valid drops; also waits out a busy transmitter
            if (bus.req_valid[gidx_q] && !bus.tx_busy) begin
               tx_start_d  = 1'b1;
               tx_data_d   = bus.req_data[gidx_q];
               req_ready_d = grant_q;
               last_d      = bus.req_last[gidx_q];
               cnt_d       = cnt_q + 1'b1;
               state_d     = S_WAIT_RISE;
            end
         end
         S_WAIT_RISE: begin
            if (bus.tx_busy) state_d = S_WAIT_FALL;
         end
         S_WAIT_FALL: begin
            if (!bus.tx_busy) begin
               if (last_q || (cnt_q == CNT_W'(MAX_BYTES))) begin
                  // last wins over the length guard when both hold
                  pkt_done_d = last_q;
                  overflow_d = !last_q;
                  grant_d    = '0;
                  ptr_d      = gidx_next;
                  cnt_d      = '0;
                  last_d     = 1'b0;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         gidx_q      <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         last_q      <= 1'b0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         req_ready_q <= '0;
         pkt_done_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gidx_q      <= gidx_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         req_ready_q <= req_ready_d;
         pkt_done_q  <= pkt_done_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.busy      = |grant_q;
   assign bus.req_ready = req_ready_q;
   assign bus.tx_start  = tx_start_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.pkt_done  = pkt_done_q;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a simple transmitter
// model, and a scoreboard checked on every tx_start.
module tb_uart_tx_arbiter;
   localparam int NR       = 4;
   localparam int MAXB     = 4;
   localparam int BUSY_CYC = 6;

   typedef struct {
      int         idx;
      logic [7:0] data;
      logic       last;
   } req_t;

   logic clock = 1'b0;
   logic reset;
   logic force_busy;
   logic [NR-1:0] hold;
   int tx_cnt = 0;
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int n_start = 0, n_done = 0, n_ovf = 0;
   int last_start_cyc = 0;
   req_t drv_q[$];
   req_t sb_q[$];
   int grant_log[$];
   int start_log[$];

   uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BYTES(MAXB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Transmitter model: busy for BUSY_CYC cycles starting the edge after tx_start
   always @(posedge clock) begin
      if (bus.tx_start && tx_cnt == 0) tx_cnt <= BUSY_CYC;
      else if (tx_cnt != 0)            tx_cnt <= tx_cnt - 1;
   end
   assign bus.tx_busy = (tx_cnt != 0) || force_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int find_drv(input int i);
      for (int j = 0; j < drv_q.size(); j++) if (drv_q[j].idx == i) return j;
      return -1;
   endfunction

   task automatic send(input int idx, input logic [7:0] d, input logic l);
      req_t r;
      r.idx = idx; r.data = d; r.last = l;
      drv_q.push_back(r);
      sb_q.push_back(r);
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic wait_quiet(input string tag, input int budget);
      bit ok;
      ok = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         tick();
         if (drv_q.size() == 0 && sb_q.size() == 0 && !bus.busy && !bus.tx_busy) ok = 1;
      end
      check({"quiet_", tag}, 32'(ok), 1);
   endtask

   task automatic wait_start(input string tag, input int target, input int budget);
      bit ok;
      ok = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         tick();
         if (n_start >= target) ok = 1;
      end
      check({"start_", tag}, 32'(ok), 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_grant"},     32'(bus.grant), 0);
      check({tag, "_busy"},      32'(bus.busy), 0);
      check({tag, "_tx_start"},  32'(bus.tx_start), 0);
      check({tag, "_tx_data"},   32'(bus.tx_data), 0);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
      check({tag, "_pkt_done"},  32'(bus.pkt_done), 0);
      check({tag, "_overflow"},  32'(bus.overflow), 0);
   endtask

   // Requesters: present the head of each queue, pop on req_ready
   initial begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      forever begin
         @(posedge clock);
         #1;
         for (int i = 0; i < NR; i++) begin
            int k;
            if (bus.req_ready[i]) begin
               k = find_drv(i);
               if (k >= 0) drv_q.delete(k);
            end
            k = find_drv(i);
            if (k >= 0 && !hold[i]) begin
               bus.req_valid[i] = 1'b1;
               bus.req_data[i]  = drv_q[k].data;
               bus.req_last[i]  = drv_q[k].last;
            end else begin
               bus.req_valid[i] = 1'b0;
            end
         end
      end
   end

   // Monitor: scoreboard on tx_start, release pulses must coincide with grant drop
   always @(negedge clock) begin
      if (bus.tx_start) begin
         int gi, k;
         gi = -1;
         k  = -1;
         for (int i = 0; i < NR; i++) if (bus.grant[i]) gi = i;
         n_start++;
         last_start_cyc = cyc;
         grant_log.push_back(gi);
         start_log.push_back(cyc);
         check("onehot_grant", 32'($onehot(bus.grant)), 1);
         check("tx_idle_at_start", 32'(bus.tx_busy), 0);
         for (int j = 0; j < sb_q.size(); j++) if (k < 0 && sb_q[j].idx == gi) k = j;
         check("sb_hit", 32'(k >= 0), 1);
         if (k >= 0) begin
            check("tx_data", 32'(bus.tx_data), 32'(sb_q[k].data));
            sb_q.delete(k);
         end
      end
      if (bus.pkt_done) begin
         n_done++;
         check("grant_clear_done", 32'(bus.grant), 0);
      end
      if (bus.overflow) begin
         n_ovf++;
         check("grant_clear_ovf", 32'(bus.grant), 0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int bs, bd, bo, c0, rep, bad_g, bad_r;
      int rr_exp[8];
      bit ok;
      reset = 1'b1;
      force_busy = 1'b0;
      hold = '0;
      repeat (3) tick();
      check_idle_outputs("reset");
      reset = 1'b0;

      // Single packet from requester 1
      grant_log.delete(); start_log.delete();
      bs = n_start; bd = n_done;
      send(1, 8'h41, 1'b0); send(1, 8'h42, 1'b0); send(1, 8'h43, 1'b1);
      ok = 0;
      for (int n = 0; n < 20 && !ok; n++) begin tick(); if (bus.busy) ok = 1; end
      check("single_busy_seen", 32'(ok), 1);
      check("single_grant", 32'(bus.grant), 32'h2);
      wait_quiet("single", 200);
      check("single_starts", n_start - bs, 3);
      check("single_done", n_done - bd, 1);
      check("single_grant_end", 32'(bus.grant), 0);
      check("single_period1", start_log[1] - start_log[0], BUSY_CYC + 3);
      check("single_period2", start_log[2] - start_log[1], BUSY_CYC + 3);

      // Pointer now 2: requester 2 beats requester 0
      grant_log.delete();
      send(0, 8'h10, 1'b1); send(2, 8'h20, 1'b1);
      wait_quiet("ptr2", 200);
      check("ptr2_first", grant_log[0], 2);
      check("ptr2_second", grant_log[1], 0);

      // Round robin: every requester keeps posting 1-byte packets
      grant_log.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NR; i++) send(i, 8'(8'h50 + r * NR + i), 1'b1);
      wait_quiet("rr", 400);
      rr_exp = '{1, 2, 3, 0, 1, 2, 3, 0};
      check("rr_len", grant_log.size(), 8);
      for (int k = 0; k < 8; k++) check($sformatf("rr_order%0d", k), grant_log[k], rr_exp[k]);
      rep = 0;
      for (int k = 1; k < grant_log.size(); k++) if (grant_log[k] == grant_log[k-1]) rep++;
      check("rr_no_repeat", rep, 0);

      // Stall: requester 0 drops valid after byte 1; requester 2 must wait
      grant_log.delete();
      bs = n_start; bd = n_done;
      send(0, 8'h60, 1'b0); send(0, 8'h61, 1'b0); send(0, 8'h62, 1'b1);
      wait_start("stall_b1", bs + 1, 50);
      hold[0] = 1'b1;
      send(2, 8'h70, 1'b1);
      bad_g = 0; bad_r = 0; c0 = n_start;
      repeat (20) begin
         tick();
         if (bus.grant !== 4'b0001) bad_g++;
         if (bus.req_ready[2]) bad_r++;
      end
      check("stall_grant", bad_g, 0);
      check("stall_no_start", n_start, c0);
      check("stall_ignore_r2", bad_r, 0);
      hold[0] = 1'b0;
      wait_quiet("stall", 300);
      check("stall_len", grant_log.size(), 4);
      check("stall_order3", grant_log[2], 0);
      check("stall_order4", grant_log[3], 2);
      check("stall_done", n_done - bd, 2);

      // Length guard: requester 3 streams MAXB bytes without last
      grant_log.delete();
      bs = n_start; bd = n_done; bo = n_ovf;
      for (int b = 0; b < MAXB; b++) send(3, 8'(8'h80 + b), 1'b0);
      wait_start("ovf_b1", bs + 1, 50);
      check("ovf_grant", 32'(bus.grant), 32'h8);
      wait_quiet("ovf", 300);
      check("ovf_starts", n_start - bs, MAXB);
      check("ovf_pulse", n_ovf - bo, 1);
      check("ovf_no_done", n_done - bd, 0);
      // Pointer wrapped to 0: requester 0 beats requester 3
      grant_log.delete();
      send(3, 8'h90, 1'b1); send(0, 8'hA0, 1'b1);
      wait_quiet("ovf_ptr", 200);
      check("ovf_ptr_first", grant_log[0], 0);
      check("ovf_ptr_second", grant_log[1], 3);

      // Reset during WAIT_FALL of byte 2
      grant_log.delete();
      bs = n_start; bd = n_done;
      send(1, 8'hB0, 1'b0); send(1, 8'hB1, 1'b0); send(1, 8'hB2, 1'b1);
      wait_start("rst_b2", bs + 2, 100);
      ok = 0;
      for (int n = 0; n < 10 && !ok; n++) begin tick(); if (bus.tx_busy) ok = 1; end
      check("rst_busy_seen", 32'(ok), 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle_outputs("rst_mid");
      tick();
      check("rst_regrant", 32'(bus.grant), 32'h2);
      check("rst_tx_still_busy", 32'(bus.tx_busy), 1);
      check("rst_withheld", n_start, bs + 2);
      wait_quiet("rst", 200);
      check("rst_done", n_done - bd, 1);
      check("rst_starts", n_start - bs, 3);

      // Transmitter busy when the grant lands
      bs = n_start;
      force_busy = 1'b1;
      send(2, 8'hC0, 1'b1);
      repeat (10) tick();
      check("bstart_grant", 32'(bus.grant), 32'h4);
      check("bstart_withheld", n_start, bs);
      c0 = cyc;
      force_busy = 1'b0;
      wait_start("bstart", bs + 1, 20);
      check("bstart_cycle", last_start_cyc, c0 + 1);
      wait_quiet("bstart", 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
